uv_levels_collector: RTL and testbench
======================================

// Module: uv_levels_collector
// PURPOSE
//  Initiator side of the UV cost engine interface. Collects up to BLOCK_SIZE quantized
//  4x4 level blocks (16 coeffs each) over a valid/ready stream and packs them into the wide bus.
//  Pulses the engine's start, holds the bus stable until the engine's done, captures the 32b sum.
//  Returns the sum on a valid/ready result port. Sits between the UV quantizer and the cost engine.
// PARAMETERS
//  BIT_WIDTH   16    width of one signed level coefficient
//  BLOCK_SIZE  8     4x4 blocks per group (UV macroblock = 4 U + 4 V)
//  CLIP_MAX    2047  saturation magnitude, used only when UV_LEVEL_CLIP_EN is defined
// PORTS
//  clk          in   1                        clock
//  rst_n        in   1                        reset, asynchronous, active-low
//  blk_valid    in   1                        input block valid
//  blk_ready    out  1                        input block ready
//  blk_last     in   1                        current block is last of group (early close)
//  blk_levels   in   BIT_WIDTH*16             coeff j at [BIT_WIDTH*j+:BIT_WIDTH], signed
//  cost_start   out  1                        one-cycle start pulse to cost engine
//  cost_levels  out  BIT_WIDTH*16*BLOCK_SIZE  block i at [BIT_WIDTH*16*i+:BIT_WIDTH*16]
//  cost_done    in   1                        engine done pulse; cost_sum valid same cycle
//  cost_sum     in   32                       engine sum of squares
//  res_valid    out  1                        result valid
//  res_ready    in   1                        result accepted
//  res_sum      out  32                       captured sum
//  res_nblk     out  4                        blocks written in group (1..BLOCK_SIZE)
//  busy         out  1                        high in any state other than FILL
// BEHAVIOUR
//  Reset (async): state=FILL, cnt=0, all slots=0, cost_start=0, res_valid=0, res_sum=0,
//  res_nblk=0; blk_ready=1 from the first cycle after reset release.
//  FILL: blk_ready=1. On blk_valid&blk_ready: write blk_levels into slot[cnt], cnt++.
//   Group closes on accepting block with cnt==BLOCK_SIZE-1 or blk_last=1 -> START.
//   Slots not written in the group are zero (all slots cleared on FILL entry) -> add 0.
//  START: exactly one cycle, cost_start=1, blk_ready=0 -> WAIT.
//  WAIT: blk_ready=0; cost_levels held unchanged. On cost_done=1: res_sum<=cost_sum,
//   res_nblk<=cnt -> OUT. No timeout. Engine done arrives 9 cycles after start pulse.
//  OUT: res_valid=1, res_sum/res_nblk stable. On res_ready -> FILL next cycle; cnt=0, slots
//   cleared. res_valid deasserts the cycle after the handshake.
//  Latency: last block accepted at edge N -> cost_start high N+1 -> res_valid high >= N+11.
//  cost_done outside WAIT is ignored. blk_valid while blk_ready=0 is not consumed; source holds.
//  blk_levels is not modified and no arithmetic is applied except under clip.
//  cost_levels is a registered slot array (not combinational from blk_levels).
//  rst_n mid-group or mid-WAIT: group discarded, no result. The engine is reset by the same rst_n.
// CONFIGURATION
//  UV_LEVEL_CLIP_EN defined: each coeff saturated to [-CLIP_MAX, CLIP_MAX] on slot write.
//   Max sum 16*8*2047^2 = 536346752, fits 32b.
//  Undefined: coeffs stored verbatim. Sums above 2^32-1 wrap (engine truncates); not flagged.
// TESTING
//  8 blocks, all coeffs +1, res_ready=1 -> one cost_start pulse, res_sum=128, res_nblk=8.
//  8 blocks, block 5 coeff 0 = -3, rest 0 -> res_sum=9; cost_levels[BIT_WIDTH*16*5+:BIT_WIDTH]=-3.
//  3 blocks of all +2, blk_last on 3rd -> res_sum=192, res_nblk=3, slots 3..7 all zero.
//  res_ready low 20 cycles in OUT -> res_valid, res_sum stable, blk_ready=0;
//   blk_valid held high -> no block consumed.
//  Single coeff 5000 in block 0 -> CLIP_EN: res_sum=4190209; without: res_sum=25000000.
//  rst_n pulsed during WAIT -> all outputs at reset values, next group computes correct fresh sum.

Source files
------------

// File: rtl/uv_levels_collector.sv
// uv_levels_collector
// Initiator side of the UV cost engine interface. Accepts up to BLOCK_SIZE
// quantized 4x4 level blocks, packs them into a registered wide bus, starts
// the cost engine, waits for done, and offers the captured sum on a
// valid/ready result port.
// Optional build macro: UV_LEVEL_CLIP_EN saturates every coefficient to
// [-CLIP_MAX, CLIP_MAX] as it is written into its slot.
module uv_levels_collector #(
    parameter int BIT_WIDTH  = 16,
    parameter int BLOCK_SIZE = 8,
    parameter int CLIP_MAX   = 2047
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               blk_valid,
    output logic                               blk_ready,
    input  logic                               blk_last,
    input  logic [BIT_WIDTH*16-1:0]            blk_levels,
    output logic                               cost_start,
    output logic [BIT_WIDTH*16*BLOCK_SIZE-1:0] cost_levels,
    input  logic                               cost_done,
    input  logic [31:0]                        cost_sum,
    output logic                               res_valid,
    input  logic                               res_ready,
    output logic [31:0]                        res_sum,
    output logic [3:0]                         res_nblk,
    output logic                               busy
);

    localparam int BLK_W = BIT_WIDTH * 16;

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t                      r_state;
    state_t                      w_next;
    logic [3:0]                  r_cnt;
    logic [BLK_W*BLOCK_SIZE-1:0] r_slots;
    logic [31:0]                 r_res_sum;
    logic [3:0]                  r_res_nblk;
    logic [BLK_W-1:0]            w_wr_blk;
    logic                        w_accept;
    logic                        w_close;
    logic                        w_clear;

`ifdef UV_LEVEL_CLIP_EN
    localparam logic signed [BIT_WIDTH-1:0] C_POS = BIT_WIDTH'(CLIP_MAX);
    localparam logic signed [BIT_WIDTH-1:0] C_NEG = BIT_WIDTH'(-CLIP_MAX);

    function automatic logic signed [BIT_WIDTH-1:0] sat_coef(
        input logic signed [BIT_WIDTH-1:0] v
    );
        if (v > C_POS)
            return C_POS;
        else if (v < C_NEG)
            return C_NEG;
        else
            return v;
    endfunction

    // Saturate each coefficient of the incoming block before it is stored
    always_comb begin
        w_wr_blk = '0;
        for (int j = 0; j < 16; j++)
            w_wr_blk[BIT_WIDTH*j +: BIT_WIDTH] = sat_coef(blk_levels[BIT_WIDTH*j +: BIT_WIDTH]);
    end
`else
    assign w_wr_blk = blk_levels;
`endif

    assign w_accept = blk_valid & blk_ready;
    assign w_close  = w_accept & ((r_cnt == 4'(BLOCK_SIZE - 1)) | blk_last);
    assign w_clear  = (r_state == S_OUT) & res_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_FILL;
        else
            r_state <= w_next;
    end

    // Next-state and state-decoded handshake outputs
    always_comb begin
        w_next     = r_state;
        blk_ready  = 1'b0;
        cost_start = 1'b0;
        res_valid  = 1'b0;
        busy       = 1'b1;
        case (r_state)
            S_FILL: begin
                blk_ready = 1'b1;
                busy      = 1'b0;
                if (w_close)
                    w_next = S_START;
            end
            S_START: begin
                cost_start = 1'b1;
                w_next     = S_WAIT;
            end
            S_WAIT: begin
                if (cost_done)
                    w_next = S_WAIT == r_state ? S_OUT : r_state;
            end
            S_OUT: begin
                res_valid = 1'b1;
                if (res_ready)
                    w_next = S_FILL;
            end
            default: w_next = S_FILL;
        endcase
    end

    // Block counter: advances per accepted block, cleared when the result is taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (w_clear)
            r_cnt <= '0;
        else if (w_accept)
            r_cnt <= r_cnt + 4'd1;
    end

    // Slot array: written one block per accept, wiped so unused slots read as zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slots <= '0;
        end else if (w_clear) begin
            r_slots <= '0;
        end else if (w_accept) begin
            for (int i = 0; i < BLOCK_SIZE; i++)
                if (r_cnt == 4'(i))
                    r_slots[BLK_W*i +: BLK_W] <= w_wr_blk;
        end
    end

    // Capture the engine result only while waiting for it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_sum  <= '0;
            r_res_nblk <= '0;
        end else if ((r_state == S_WAIT) && cost_done) begin
            r_res_sum  <= cost_sum;
            r_res_nblk <= r_cnt;
        end
    end

    assign cost_levels = r_slots;
    assign res_sum     = r_res_sum;
    assign res_nblk    = r_res_nblk;

endmodule

// File: tb/tb_uv_levels_collector.sv
// Testbench for uv_levels_collector: a cost-engine model answers each start
// pulse, a stimulus-derived reference predicts bus contents and sums, and a
// per-cycle compare process checks the DUT against it.
module tb_uv_levels_collector;

    localparam int BW    = 16;
    localparam int BS    = 8;
    localparam int CM    = 2047;
    localparam int BLK_W = BW * 16;
    localparam int BUS_W = BLK_W * BS;

    logic             clk;
    logic             rst_n;
    logic             blk_valid;
    logic             blk_ready;
    logic             blk_last;
    logic [BLK_W-1:0] blk_levels;
    logic             cost_start;
    logic [BUS_W-1:0] cost_levels;
    logic             cost_done;
    logic [31:0]      cost_sum;
    logic             res_valid;
    logic             res_ready;
    logic [31:0]      res_sum;
    logic [3:0]       res_nblk;
    logic             busy;

    uv_levels_collector #(.BIT_WIDTH(BW), .BLOCK_SIZE(BS), .CLIP_MAX(CM)) dut (
        .clk(clk), .rst_n(rst_n),
        .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_last(blk_last),
        .blk_levels(blk_levels),
        .cost_start(cost_start), .cost_levels(cost_levels),
        .cost_done(cost_done), .cost_sum(cost_sum),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_sum(res_sum), .res_nblk(res_nblk), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_bus(input string name, input logic [BUS_W-1:0] act, input logic [BUS_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: bus differs, got low 64b 0x%0h, expected low 64b 0x%0h",
                     name, act[63:0], exp[63:0]);
        end
    endtask

    // ---------------- reference model ----------------
    int               g_coef [BS][16];
    logic [BUS_W-1:0] exp_bus;
    logic [31:0]      exp_sum;
    logic [3:0]       exp_nblk;
    bit               exp_active = 1'b0;
    int               acc_cyc;
    int               starts_seen = 0;
    logic [31:0]      got_sum;
    logic [3:0]       got_nblk;
    logic [BUS_W-1:0] got_bus;

    function automatic int mcoef(input int v);
`ifdef UV_LEVEL_CLIP_EN
        if (v > CM) return CM;
        if (v < -CM) return -CM;
`endif
        return v;
    endfunction

    // ---------------- cost engine model ----------------
    function automatic logic [31:0] engine_sum(input logic [BUS_W-1:0] bus);
        longint s;
        logic signed [BW-1:0] c;
        s = 0;
        for (int i = 0; i < BS * 16; i++) begin
            c = bus[BW*i +: BW];
            s += longint'(c) * longint'(c);
        end
        return s[31:0];
    endfunction

    int timer = 0;
    initial begin
        cost_done = 1'b0;
        cost_sum  = '0;
        forever begin
            @(posedge clk);
            #1;
            cost_done = 1'b0;
            cost_sum  = $urandom;
            if (!rst_n) begin
                timer = 0;
            end else if (timer > 0) begin
                timer--;
                if (timer == 0) begin
                    cost_done = 1'b1;
                    cost_sum  = engine_sum(cost_levels);
                end
            end else if (cost_start) begin
                timer = 9;
            end else if ((res_valid || !busy) && $urandom_range(0, 5) == 0) begin
                cost_done = 1'b1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            chk("blk_ready_vs_busy", blk_ready, !busy);
            if (exp_active) begin
                chk_bus("cost_levels", cost_levels, exp_bus);
                if (cost_start) starts_seen++;
                if (res_valid) begin
                    chk("res_sum", res_sum, exp_sum);
                    chk("res_nblk", res_nblk, exp_nblk);
                end
            end else begin
                chk("idle_res_valid", res_valid, 1'b0);
                chk("idle_cost_start", cost_start, 1'b0);
            end
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic fill_const(input int v);
        for (int b = 0; b < BS; b++)
            for (int j = 0; j < 16; j++)
                g_coef[b][j] = v;
    endtask

    task automatic fill_rand(input int mode);
        for (int b = 0; b < BS; b++)
            for (int j = 0; j < 16; j++) begin
                case (mode)
                    0: g_coef[b][j] = int'($urandom_range(0, 6)) - 3;
                    1: g_coef[b][j] = int'($urandom_range(0, 65535)) - 32768;
                    default: g_coef[b][j] = (($urandom_range(0, 1) == 1) ? CM : -CM)
                                            + int'($urandom_range(0, 200)) - 100;
                endcase
            end
    endtask

    task automatic send_blocks(input int n, input bit use_last);
        logic [BUS_W-1:0] bus;
        longint s;
        int v;
        int t;
        bus = '0;
        s   = 0;
        for (int b = 0; b < n; b++)
            for (int j = 0; j < 16; j++) begin
                v = mcoef(g_coef[b][j]);
                bus[BLK_W*b + BW*j +: BW] = BW'(v);
                s += longint'(v) * longint'(v);
            end
        @(posedge clk);
        #1;
        for (int b = 0; b < n; b++) begin
            if ($urandom_range(0, 3) == 0) begin
                blk_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            blk_valid = 1'b1;
            blk_last  = use_last && (b == n - 1);
            for (int j = 0; j < 16; j++)
                blk_levels[BW*j +: BW] = BW'(g_coef[b][j]);
            t = 0;
            forever begin
                @(negedge clk);
                if (blk_ready) break;
                t++;
                if (t > 50) begin
                    chk("blk_ready_timeout", 1'b0, 1'b1);
                    break;
                end
            end
            @(posedge clk);
            #1;
            if (b == n - 1) begin
                exp_bus    = bus;
                exp_sum    = s[31:0];
                exp_nblk   = 4'(n);
                exp_active = 1'b1;
                acc_cyc    = cyc;
            end
        end
        blk_valid = 1'b0;
        blk_last  = 1'b0;
    endtask

    task automatic get_result(input int hold, input bit hold_valid, input int starts0);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!res_valid && t < 200);
        if (!res_valid) begin
            chk("res_valid_timeout", 1'b0, 1'b1);
        end else begin
            chk("latency_ge_10", 64'(cyc - acc_cyc >= 10), 1);
            got_sum  = res_sum;
            got_nblk = res_nblk;
            got_bus  = cost_levels;
        end
        if (hold_valid) begin
            blk_valid  = 1'b1;
            blk_levels = {16{16'h1234}};
        end
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk("stall_res_valid", res_valid, 1'b1);
            chk("stall_blk_ready", blk_ready, 1'b0);
        end
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        blk_valid = 1'b0;
        @(posedge clk);
        #1;
        res_ready  = 1'b0;
        exp_active = 1'b0;
        @(negedge clk);
        chk("post_res_valid", res_valid, 1'b0);
        chk("post_busy", busy, 1'b0);
        chk_bus("post_slots_clear", cost_levels, '0);
        chk("one_start_pulse", 64'(starts_seen - starts0), 1);
    endtask

    task automatic run_group(input int n, input bit use_last, input int hold, input bit hold_valid);
        int s0;
        s0 = starts_seen;
        send_blocks(n, use_last);
        get_result(hold, hold_valid, s0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cost_start"}, cost_start, 1'b0);
        chk({tag, "_res_valid"}, res_valid, 1'b0);
        chk({tag, "_res_sum"}, res_sum, 32'd0);
        chk({tag, "_res_nblk"}, res_nblk, 4'd0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk_bus({tag, "_cost_levels"}, cost_levels, '0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [BW-1:0] c16;
        int nb;
        rst_n      = 1'b0;
        blk_valid  = 1'b0;
        blk_last   = 1'b0;
        blk_levels = '0;
        res_ready  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("after_reset_blk_ready", blk_ready, 1'b1);

        // all +1, full group
        fill_const(1);
        run_group(8, 1'b0, 0, 1'b0);
        chk("t1_sum", got_sum, 32'd128);
        chk("t1_nblk", got_nblk, 4'd8);

        // single -3 in block 5
        fill_const(0);
        g_coef[5][0] = -3;
        run_group(8, 1'b0, 1, 1'b0);
        chk("t2_sum", got_sum, 32'd9);
        c16 = got_bus[BLK_W*5 +: BW];
        chk("t2_slot5_coef0", c16, 16'hFFFD);

        // early close after 3 blocks
        fill_const(2);
        run_group(3, 1'b1, 0, 1'b0);
        chk("t3_sum", got_sum, 32'd192);
        chk("t3_nblk", got_nblk, 4'd3);
        chk_bus("t3_slots_3_7_zero", got_bus & ~{{(BUS_W-3*BLK_W){1'b0}}, {(3*BLK_W){1'b1}}}, '0);

        // result stall with input held valid
        fill_rand(0);
        run_group(8, 1'b0, 20, 1'b1);

        // single large coefficient
        fill_const(0);
        g_coef[0][0] = 5000;
        run_group(1, 1'b1, 0, 1'b0);
`ifdef UV_LEVEL_CLIP_EN
        chk("t5_sum_clip", got_sum, 32'd4190209);
`else
        chk("t5_sum", got_sum, 32'd25000000);
`endif

        // extreme negative coefficients: wraps without clip
        fill_const(-32768);
        run_group(8, 1'b0, 0, 1'b0);

        // reset pulsed during WAIT
        fill_rand(1);
        send_blocks(5, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        exp_active = 1'b0;
        rst_n      = 1'b0;
        @(negedge clk);
        chk_reset_vals("wait_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        fill_const(1);
        g_coef[2][7] = 10;
        run_group(4, 1'b1, 0, 1'b0);
        chk("t6_fresh_sum", got_sum, 32'd163);

        // randomized groups
        for (int g = 0; g < 24; g++) begin
            fill_rand(int'($urandom_range(0, 2)));
            nb = int'($urandom_range(1, BS));
            run_group(nb, (nb < BS) ? 1'b1 : 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 3)), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
